decode_dp: RTL and testbench

//  LZS decode datapath: the write side of the 2048-byte history window.
//  - Consumes decoded tokens: literal bytes, or (offset, length) back-references.
//  - Replays references out of the history RAM.
//  - Packs output bytes little-endian into 64-bit words for the output FIFO,

---
 rtl/decode_dp.sv | 213 +++++++++++++++++++++
 tb/tb_decode_dp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dp.sv
// LZS decode datapath: applies literal / back-reference tokens to a 2^HIST_AW-byte
// history window and packs the resulting byte stream little-endian into 64-bit words.
module decode_dp #(
    parameter int LEN_W   = 8,
    parameter int HIST_AW = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               tok_valid,
    output logic               tok_ready,
    input  logic               tok_is_match,
    input  logic [7:0]         tok_literal,
    input  logic [HIST_AW-1:0] tok_offset,
    input  logic [LEN_W-1:0]   tok_length,
    input  logic               tok_last,
    input  logic               fo_full,
    output logic               fo_we,
    output logic [63:0]        fo_data,
    output logic               fo_last,
    output logic [3:0]         fo_nbytes,
    output logic               done,
    output logic               err
);

    localparam int DEPTH = 1 << HIST_AW;
    localparam int CW    = HIST_AW + 1;
    localparam logic [CW-1:0] PROD_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {S_PROC, S_COPY, S_FLUSH, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic               r_act;
    logic [HIST_AW-1:0] r_wptr;
    logic [HIST_AW-1:0] r_rd;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_clast;
    logic [CW-1:0]      r_prod;
    logic               r_err;

    // Write stage: one byte per cycle headed for history and packer.
    logic               r_bv;
    logic               r_bsrc;
    logic [7:0]         r_blit;
    logic [HIST_AW-1:0] r_baddr;

    logic [7:0]         r_mem [DEPTH];
    logic [7:0]         r_ram_q;
    logic               r_fwd;
    logic [7:0]         r_fwd_data;

    logic [63:0]        r_word;
    logic [2:0]         r_bidx;
    logic               r_pend;
    logic [63:0]        r_pword;
    logic               r_plast;
    logic [3:0]         r_pnbytes;

    logic               w_stall;
    logic               w_run;
    logic               w_tok_ready;
    logic               w_accept;
    logic               w_lit_acc;
    logic               w_match_go;
    logic               w_issue;
    logic               w_flush_load;
    logic [7:0]         w_bdata;

    assign w_stall    = r_pend && fo_full;
    assign w_run      = ce && !w_stall;
    assign w_accept   = w_tok_ready && tok_valid;
    assign w_lit_acc  = w_accept && !tok_is_match;
    assign w_match_go = w_accept && tok_is_match && (tok_offset != '0) && (tok_length != '0);
    assign w_bdata    = r_bsrc ? (r_fwd ? r_fwd_data : r_ram_q) : r_blit;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_PROC;
        else if (w_run)
            r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nxt  = r_state;
        w_tok_ready  = 1'b0;
        w_issue      = 1'b0;
        w_flush_load = 1'b0;
        case (r_state)
            S_PROC: begin
                w_tok_ready = r_act && ce && !w_stall;
                if (w_match_go)
                    w_state_nxt = S_COPY;
                else if (w_accept && tok_last)
                    w_state_nxt = S_FLUSH;
            end
            S_COPY: begin
                w_issue = w_run;
                if (w_run && r_cnt == LEN_W'(1))
                    w_state_nxt = r_clast ? S_FLUSH : S_PROC;
            end
            S_FLUSH: begin
                // Wait until the last byte has landed in the packer and any full word is out.
                if (w_run && !r_pend && !r_bv) begin
                    w_flush_load = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_PROC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act   <= 1'b0;
            r_wptr  <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_clast <= 1'b0;
            r_prod  <= '0;
            r_err   <= 1'b0;
            r_bv    <= 1'b0;
            r_bsrc  <= 1'b0;
            r_blit  <= '0;
            r_baddr <= '0;
        end else if (w_run) begin
            r_act <= 1'b1;
            r_bv  <= 1'b0;
            if (w_lit_acc) begin
                r_bv    <= 1'b1;
                r_bsrc  <= 1'b0;
                r_blit  <= tok_literal;
                r_baddr <= r_wptr;
                r_wptr  <= r_wptr + 1'b1;
                if (r_prod != PROD_MAX)
                    r_prod <= r_prod + 1'b1;
            end
            if (w_accept && tok_is_match) begin
                if (tok_offset == '0 || {1'b0, tok_offset} > r_prod)
                    r_err <= 1'b1;
                r_rd    <= r_wptr - tok_offset;
                r_cnt   <= tok_length;
                r_clast <= tok_last;
            end
            if (w_issue) begin
                r_bv    <= 1'b1;
                r_bsrc  <= 1'b1;
                r_baddr <= r_wptr;
                r_wptr  <= r_wptr + 1'b1;
                r_rd    <= r_rd + 1'b1;
                r_cnt   <= r_cnt - 1'b1;
                if (r_prod != PROD_MAX)
                    r_prod <= r_prod + 1'b1;
            end
        end
    end

    // NOTE: the history RAM has no reset so it maps onto block RAM; stale contents are harmless.
    // Read-first RAM plus a bypass register for a read hitting the byte being written.
    always_ff @(posedge clk) begin
        if (w_run && !rst) begin
            if (r_bv)
                r_mem[r_baddr] <= w_bdata;
            r_ram_q    <= r_mem[r_rd];
            r_fwd      <= r_bv && (r_baddr == r_rd);
            r_fwd_data <= w_bdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word    <= '0;
            r_bidx    <= '0;
            r_pend    <= 1'b0;
            r_pword   <= '0;
            r_plast   <= 1'b0;
            r_pnbytes <= '0;
        end else if (w_run) begin
            if (fo_we)
                r_pend <= 1'b0;
            if (r_bv) begin
                if (r_bidx == 3'd7) begin
                    r_pend    <= 1'b1;
                    r_pword   <= {w_bdata, r_word[55:0]};
                    r_plast   <= 1'b0;
                    r_pnbytes <= 4'd8;
                    r_word    <= '0;
                end else begin
                    r_word[{r_bidx, 3'b000} +: 8] <= w_bdata;
                end
                r_bidx <= r_bidx + 1'b1;
            end
            if (w_flush_load) begin
                r_pend    <= 1'b1;
                r_pword   <= r_word;
                r_plast   <= 1'b1;
                r_pnbytes <= {1'b0, r_bidx};
            end
        end
    end

    assign tok_ready = w_tok_ready;
    assign fo_we     = r_pend && ce && !fo_full;
    assign fo_data   = r_pword;
    assign fo_last   = r_plast;
    assign fo_nbytes = r_pnbytes;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_decode_dp.sv
// Bench for decode_dp: token table plus hand sequences; output words are checked
// against a byte-stream model through a scoreboard queue.
module tb_decode_dp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        tok_is_match = 1'b0;
    logic [7:0]  tok_literal = '0;
    logic [10:0] tok_offset = '0;
    logic [7:0]  tok_length = '0;
    logic        tok_last = 1'b0;
    logic        fo_full = 1'b0;
    logic        fo_we;
    logic [63:0] fo_data;
    logic        fo_last;
    logic [3:0]  fo_nbytes;
    logic        done;
    logic        err;

    decode_dp #(.LEN_W(8), .HIST_AW(11)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_match(tok_is_match),
        .tok_literal(tok_literal), .tok_offset(tok_offset), .tok_length(tok_length),
        .tok_last(tok_last), .fo_full(fo_full), .fo_we(fo_we), .fo_data(fo_data),
        .fo_last(fo_last), .fo_nbytes(fo_nbytes), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [3:0]  nb;
    } exp_t;

    typedef struct {
        bit         rst_before;
        bit         is_match;
        logic [7:0] lit;
        int         off;
        int         len;
        bit         last;
        bit         exp_err;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  strm[$];
    logic [63:0] m_word;
    int          m_n;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        strm.delete();
        exp_q.delete();
        m_word = '0;
        m_n    = 0;
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        strm.push_back(b);
        m_word[8*m_n +: 8] = b;
        m_n++;
        if (m_n == 8) begin
            exp_q.push_back('{data: m_word, last: 1'b0, nb: 4'd8});
            m_word = '0;
            m_n    = 0;
        end
    endfunction

    function automatic void model_tok(input bit m, input logic [7:0] lit, input int off,
                                      input int len, input bit last);
        if (!m)
            push_byte(lit);
        else if (off != 0 && off <= strm.size())
            for (int i = 0; i < len; i++)
                push_byte(strm[strm.size() - off]);
        if (last)
            exp_q.push_back('{data: m_word, last: 1'b1, nb: 4'(m_n)});
    endfunction

    function automatic vec_t mk(input bit r, input bit m, input logic [7:0] lit, input int off,
                                input int len, input bit last, input bit e);
        vec_t v;
        v.rst_before = r; v.is_match = m; v.lit = lit; v.off = off;
        v.len = len; v.last = last; v.exp_err = e;
        return v;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        tok_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic send_tok(input bit m, input logic [7:0] lit, input int off, input int len,
                            input bit last);
        int waited = 0;
        tok_valid    = 1'b1;
        tok_is_match = m;
        tok_literal  = lit;
        tok_offset   = 11'(off);
        tok_length   = 8'(len);
        tok_last     = last;
        @(negedge clk);
        while (!tok_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!tok_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL tok_accept_timeout: tok_ready=%0b after %0d cycles, required 1", tok_ready, waited);
        end
        @(posedge clk);
        #1 tok_valid = 1'b0;
        if (waited < 300)
            model_tok(m, lit, off, len, last);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        repeat (4) @(negedge clk);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every written word must match the next expected one.
    always @(negedge clk) begin
        if (!rst && fo_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("fo_unexpected_word", 64'(fo_we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("fo_data", fo_data, mon_e.data);
                check("fo_last", 64'(fo_last), 64'(mon_e.last));
                check("fo_nbytes", 64'(fo_nbytes), 64'(mon_e.nb));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_rdy;
        int bad_we;
        int we_before;

        // Token table: five streams, each preceded by a reset.
        for (int i = 1; i <= 16; i++)
            vecs.push_back(mk(i == 1, 0, 8'(i), 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h11, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'hAA, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 9, 1, 0));
        vecs.push_back(mk(1, 0, 8'h41, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h42, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h43, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h44, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 4, 4, 1, 0));
        vecs.push_back(mk(1, 0, 8'h01, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h02, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h03, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 5, 0, 1));
        vecs.push_back(mk(0, 0, 8'h09, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 8'h05, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h06, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 2, 3, 0, 0));
        vecs.push_back(mk(0, 0, 8'h07, 0, 0, 1, 0));

        // Reset values while rst is held high.
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tok_ready", 64'(tok_ready), 64'd0);
        check("rst_fo_we", 64'(fo_we), 64'd0);
        check("rst_fo_data", fo_data, 64'd0);
        check("rst_fo_last", 64'(fo_last), 64'd0);
        check("rst_fo_nbytes", 64'(fo_nbytes), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before)
                do_reset();
            send_tok(vecs[i].is_match, vecs[i].lit, vecs[i].off, vecs[i].len, vecs[i].last);
            check($sformatf("err_v%0d", i), 64'(err), 64'(vecs[i].exp_err));
            if (vecs[i].last)
                wait_done($sformatf("stream_v%0d", i));
        end

        // Window wrap: 2100 literals then a reference to the oldest reachable bytes.
        do_reset();
        for (int i = 0; i < 2100; i++)
            send_tok(0, 8'(i * 37 + 5), 0, 0, 0);
        send_tok(1, 8'h00, 2047, 8, 1);
        check("wrap_err", 64'(err), 64'd0);
        wait_done("wrap");

        // Backpressure during a long copy, then ce=0 holding a pending word.
        do_reset();
        for (int i = 0; i < 8; i++)
            send_tok(0, 8'(8'h10 + i), 0, 0, 0);
        send_tok(1, 8'h00, 8, 32, 0);
        repeat (3) @(posedge clk);
        #1 fo_full = 1'b1;
        bad_rdy = 0;
        bad_we  = 0;
        we_before = we_cnt;
        repeat (20) begin
            @(negedge clk);
            if (tok_ready) bad_rdy++;
            if (fo_we) bad_we++;
        end
        check("full_tok_ready_cycles", 64'(bad_rdy), 64'd0);
        check("full_fo_we_cycles", 64'(bad_we), 64'd0);
        @(posedge clk);
        #1 begin fo_full = 1'b0; ce = 1'b0; end
        repeat (5) @(negedge clk);
        check("ce0_words", 64'(we_cnt - we_before), 64'd0);
        @(posedge clk);
        #1 ce = 1'b1;
        send_tok(0, 8'h99, 0, 0, 1);
        wait_done("backpressure");

        // Reference before any data, then reset in the middle of the copy.
        do_reset();
        send_tok(1, 8'h00, 5, 20, 0);
        check("first_tok_off5_err", 64'(err), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midcopy_tok_ready", 64'(tok_ready), 64'd0);
        check("midcopy_fo_we", 64'(fo_we), 64'd0);
        check("midcopy_fo_data", fo_data, 64'd0);
        check("midcopy_fo_last", 64'(fo_last), 64'd0);
        check("midcopy_fo_nbytes", 64'(fo_nbytes), 64'd0);
        check("midcopy_done", 64'(done), 64'd0);
        check("midcopy_err", 64'(err), 64'd0);
        #1 rst = 1'b0;
        model_reset();
        send_tok(0, 8'h5A, 0, 0, 1);
        check("recover_err", 64'(err), 64'd0);
        wait_done("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
